// File: rtl/rng_share_pkg.sv
// Shared types and helpers for the LFSR word-sharing arbiter.
package rng_share_pkg;

    localparam int RND_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    // Bits needed to hold 0..gap, never less than one.
    function automatic int cnt_width(input int gap);
        int w;
        w = 1;
        for (int i = 1; i < 12; i++) begin
            if ((1 << i) < gap + 1) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rng_share_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int PW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [PW-1:0]      o_idx,
    output logic               o_any
);

    int w_k;
    logic [PW-1:0] w_kidx;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_k      = 0;
        w_kidx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_k = int'(i_ptr) + i;
            if (w_k >= NUM_REQ) w_k = w_k - NUM_REQ;
            w_kidx = PW'(w_k);
            if (!o_any && i_req[w_kidx]) begin
                o_any            = 1'b1;
                o_onehot[w_kidx] = 1'b1;
                o_idx            = w_kidx;
            end
        end
    end

endmodule

// File: rtl/rng_share_arbiter.sv
// Shares one LFSR word among requesters with a cooldown between grants.
// Optional grant counter port under RNG_SHARE_ARBITER_STATS_EN.
module rng_share_arbiter
    import rng_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int RND_W   = RND_W_DEFAULT,
    parameter int MIN_GAP = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [RND_W-1:0]   rnd_number,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [RND_W-1:0]   rnd_out,
    output logic               rnd_valid,
    output logic               busy
`ifdef RNG_SHARE_ARBITER_STATS_EN
    ,
    output logic [7:0]         grant_cnt
`endif
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = cnt_width(MIN_GAP);

    state_t               r_state;
    logic [PW-1:0]        r_ptr;
    logic [PW-1:0]        r_win;
    logic [CW-1:0]        r_cnt;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [RND_W-1:0]     r_rnd;
    logic                 r_valid;

    logic [NUM_REQ-1:0]   w_onehot;
    logic [PW-1:0]        w_idx;
    logic                 w_any;

    rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_onehot(w_onehot),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // GRANT always finishes regardless of en so gnt stays a single pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_rnd   <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (en && w_any) begin
                        r_gnt   <= w_onehot;
                        r_rnd   <= rnd_number;
                        r_valid <= 1'b1;
                        r_win   <= w_idx;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    r_gnt   <= '0;
                    r_valid <= 1'b0;
                    if (r_win == PW'(NUM_REQ - 1)) r_ptr <= '0;
                    else                            r_ptr <= r_win + 1'b1;
                    if (MIN_GAP == 0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt   <= CW'(MIN_GAP);
                        r_state <= COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    if (en) begin
                        if (r_cnt <= CW'(1)) begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign rnd_out   = r_rnd;
    assign rnd_valid = r_valid;
    assign busy      = (r_state != IDLE);

`ifdef RNG_SHARE_ARBITER_STATS_EN
    logic [7:0] r_gcnt;

    // Counted on entry to GRANT, the only point where en is known high.
    always_ff @(posedge clk) begin
        if (!rst_n) r_gcnt <= '0;
        else if (r_state == IDLE && en && w_any) r_gcnt <= r_gcnt + 8'd1;
    end

    assign grant_cnt = r_gcnt;
`endif

endmodule

// File: tb/tb_rng_share_arbiter.sv
// Randomised bench for rng_share_arbiter against a transaction-level model.
module tb_rng_share_arbiter;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int GAP = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [W-1:0] rnd_number;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [W-1:0] rnd_out;
    logic         rnd_valid;
    logic         busy;
`ifdef RNG_SHARE_ARBITER_STATS_EN
    logic [7:0]   grant_cnt;
`endif

    rng_share_arbiter #(
        .NUM_REQ(N),
        .RND_W  (W),
        .MIN_GAP(GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rnd_number(rnd_number),
        .req       (req),
        .gnt       (gnt),
        .rnd_out   (rnd_out),
        .rnd_valid (rnd_valid),
        .busy      (busy)
`ifdef RNG_SHARE_ARBITER_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_g = -1;
    int exp_space = 0;

    // Model: a pending-grant flag, a remaining cooldown in enabled cycles,
    // the rotating priority start, and the last word handed out.
    bit       m_gnt;
    int       m_win;
    int       m_ptr;
    int       m_wait;
    bit [W-1:0] m_word;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic timeout(input string tag);
        n_vec++;
        n_err++;
        $display("FAIL %s timeout (cyc %0d)", tag, cyc);
    endtask

    task automatic model_update();
        if (!rst_n) begin
            m_gnt  = 0;
            m_ptr  = 0;
            m_wait = 0;
            m_word = '0;
        end else if (m_gnt) begin
            m_gnt  = 0;
            m_ptr  = (m_win + 1) % N;
            m_wait = GAP;
        end else if (m_wait > 0) begin
            if (en) m_wait--;
        end else if (en && req != 0) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (!m_gnt && req[j]) begin
                    m_gnt  = 1;
                    m_win  = j;
                    m_word = rnd_number;
                end
            end
        end
    endtask

    task automatic compare();
        logic [N-1:0] eg;
        eg = m_gnt ? N'(1 << m_win) : '0;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("rnd_valid", 32'(rnd_valid), 32'(m_gnt));
        chk("rnd_out", 32'(rnd_out), 32'(m_word));
        chk("busy", 32'(busy), 32'(m_gnt || m_wait > 0));
        if (!rst_n) last_g = -1;
        if (gnt != 0) begin
            if (exp_space != 0 && last_g >= 0)
                chk("spacing", 32'(cyc - last_g), 32'(exp_space));
            last_g = cyc;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        cyc++;
        @(negedge clk);
        compare();
    endtask

    initial begin
        int gcount;
        bit seen;

        rst_n = 1'b0;
        en = 1'b1;
        req = 4'b1111;
        rnd_number = '0;

        for (int i = 0; i < 2; i++) begin
            rnd_number = W'($urandom);
            step();
        end

        rst_n = 1'b1;
        exp_space = GAP + 2;
        gcount = 0;
        for (int i = 0; i < 100; i++) begin
            rnd_number = W'($urandom);
            step();
            if (gnt != 0) begin
                chk("order", 32'(gnt), 32'(1 << (gcount % N)));
                gcount++;
            end
        end
        chk("fair_count", 32'(gcount), 32'd6);
        exp_space = 0;

        req = 4'b0100;
        rnd_number = 16'hBEEF;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (gnt != 0) begin
                seen = 1;
                chk("beef_gnt", 32'(gnt), 32'h4);
                chk("beef_word", 32'(rnd_out), 32'hBEEF);
            end
        end
        if (!seen) timeout("single_req");

        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            rnd_number = W'($urandom);
            step();
            seen = (m_wait == 10);
        end
        if (!seen) timeout("freeze_wait");
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rnd_number = W'($urandom);
            step();
        end
        en = 1'b1;
        exp_space = GAP + 2 + 5;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            rnd_number = W'($urandom);
            step();
            seen = (gnt != 0);
        end
        if (!seen) timeout("freeze_grant");
        exp_space = 0;

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req = 4'b0011;
        seen = 0;
        for (int i = 0; i < 5 && !seen; i++) begin
            rnd_number = W'($urandom);
            step();
            seen = (gnt != 0);
        end
        if (!seen) timeout("withdraw_first");
        step();
        req = 4'b0001;
        for (int i = 0; i < 60; i++) begin
            rnd_number = W'($urandom);
            step();
            chk("no_g1", 32'(gnt[1]), 32'd0);
        end

        req = 4'b1000;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            rnd_number = W'($urandom);
            step();
            seen = (m_wait == 8) && (gnt == 0);
        end
        if (!seen) timeout("rst_mid_wait");
        rst_n = 1'b0;
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_regrant", 32'(gnt), 32'h8);

        for (int i = 0; i < 1500; i++) begin
            rnd_number = W'($urandom);
            en = ($urandom % 8) != 0;
            if ($urandom % 6 == 0) req = N'($urandom);
            rst_n = ($urandom % 200) != 0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rng_share_arbiter.md
Name: rng_share_arbiter

Overview:
- Round-robin arbiter that shares the single 16-bit LFSR random word among NUM_REQ requesters.
- Sits between the lfsr_64bit output and the consumer blocks (cookie game logic, display scrambler, test hooks).
- Hands out one sampled word per grant.
- Enforces a minimum LFSR-advance gap between grants so no two requesters receive correlated words.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- RND_W, 16, width of the random word.
- MIN_GAP, 16, cooldown cycles after each grant before the next arbitration (0..255).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  design enable; low freezes the arbiter.
- rnd_number  input  RND_W  live LFSR word.
- req  input  NUM_REQ  level request per requester, held until granted.
- gnt  output  NUM_REQ  one-hot, one-cycle grant pulse.
- rnd_out  output  RND_W  word delivered with the grant; holds until the next grant.
- rnd_valid  output  1  one-cycle pulse, coincident with gnt.
- busy  output  1  high in GRANT or COOLDOWN.

Behaviour:
- Clock and reset: one clock domain; rst_n is synchronous and active-low.
- Reset values: gnt=0, rnd_valid=0, rnd_out=0, busy=0, state=IDLE, rr pointer=0 (requester 0 highest priority), gap counter=0.
- FSM states: IDLE, GRANT, COOLDOWN.
- IDLE:
  - If en && |req, pick the first set bit searching upward from ptr with wrap.
  - Register gnt=onehot(winner) and rnd_out=rnd_number sampled in this cycle; set rnd_valid=1; go to GRANT.
  - Latency from a sampled req to gnt is exactly 1 cycle.
- GRANT:
  - Lasts 1 cycle; gnt and rnd_valid are high only here.
  - ptr <= winner+1 mod NUM_REQ.
  - If MIN_GAP==0, go to IDLE; else load gap counter=MIN_GAP and go to COOLDOWN.
  - gnt/rnd_valid clear on exit.
- COOLDOWN:
  - Counter decrements each cycle that en=1; go to IDLE when it reaches 1→0.
  - Requests are ignored.
- Grant spacing under continuous requests: MIN_GAP+2 cycles (18 at default).
- en=0 in any state:
  - No state, counter, or pointer change.
  - An in-flight GRANT cycle still completes, so gnt is never longer than 1 cycle.
  - rnd_out holds.
- Request withdrawal: a requester may drop req before it is granted; it is simply not selected. No grant is issued if req==0.
- Simultaneous requests: the round-robin order guarantees each active requester is served within NUM_REQ grants.
- ptr wrap: NUM_REQ-1 → 0.
- Reset mid-operation: a synchronous return to reset values on the next edge, including clearing an active gnt pulse. Any pending request is re-arbitrated from ptr=0.
- Gap counter width: clog2(MIN_GAP+1), minimum 1.

Optional Feature:
- Macro: RNG_SHARE_ARBITER_STATS_EN.
- When defined:
  - Adds output port grant_cnt[7:0], incremented on every GRANT cycle.
  - Wraps 255→0; reset to 0; frozen while en=0.
- When undefined: the port and counter do not exist, and behaviour is otherwise identical.

Decomposition:
- Package rng_share_pkg holds:
  - RND_W_DEFAULT=16.
  - The FSM state typedef (IDLE=2'd0, GRANT=2'd1, COOLDOWN=2'd2).
  - A function for counter width.
- Sub-module rr_pick:
  - Combinational, parameterised by NUM_REQ; inputs req and ptr; outputs one-hot winner and index plus any_req.
  - Instantiated once in the arbiter.

Test Plan (NUM_REQ=4, RND_W=16, MIN_GAP=16):
- Reset: hold rst_n=0 for 2 cycles with req=4'b1111 → gnt=0, rnd_valid=0, rnd_out=16'h0000, busy=0 throughout. Release, and first gnt=4'b0001 exactly 1 cycle after the first sampled cycle.
- Single requester: req=4'b0100 held, with rnd_number=16'hBEEF in the decision cycle → next cycle gnt=4'b0100, rnd_valid=1, rnd_out=16'hBEEF. Repeat grants occur every 18 cycles.
- Fairness: req=4'b1111 held for 100 cycles → grant order 0,1,2,3,0,1 at 18-cycle spacing, each rnd_out equal to the rnd_number of its decision cycle.
- Enable freeze: drop en for 5 cycles at cooldown count 10 → counter holds at 10, and the next grant is delayed by exactly 5 cycles (spacing 23).
- Withdrawal: req=4'b0011 with ptr=0; drop req[1] during cooldown → only requester 0 is granted, and no gnt[1] pulse appears.
- Reset mid-COOLDOWN: assert rst_n=0 for 1 cycle at count 8 with req=4'b1000 → busy=0 next edge; after release, gnt=4'b1000 in 1 cycle, since ptr=0 and 3 is the only requester.
